// File: rtl/cmp_flags_stage.sv
// Two-stage pipelined relational compare: widen operands, register, then emit a packed flag word.
// Optional build macro CMP_FLAGS_SIGNED_EN selects sign extension and signed comparison.
module cmp_flags_stage #(
    parameter int A_W   = 6,
    parameter int B_W   = 7,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sclr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   a,
    input  logic [B_W-1:0]   b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       flags,
    output logic [CNT_W-1:0] cmp_count
);

    localparam int W = (A_W > B_W) ? A_W : B_W;

    // Handshake: a transfer happens on a side when its valid and ready are both
    // high at a rising edge; valid never depends on ready, ready may depend on out_ready.

    logic [W-1:0] a_w, b_w;
    logic [W-1:0] s1_a, s1_b;
    logic         s1_v, s2_v;
    logic         s1_adv, s2_adv;
    logic         eq, gt, lt, a_nz, b_nz;
    logic [7:0]   flags_d;

    always_comb begin
`ifdef CMP_FLAGS_SIGNED_EN
        a_w = W'($signed(a));
        b_w = W'($signed(b));
`else
        a_w = W'(a);
        b_w = W'(b);
`endif
    end

    always_comb begin
        eq = (s1_a == s1_b);
`ifdef CMP_FLAGS_SIGNED_EN
        gt = ($signed(s1_a) > $signed(s1_b));
        lt = ($signed(s1_a) < $signed(s1_b));
`else
        gt = (s1_a > s1_b);
        lt = (s1_a < s1_b);
`endif
        // Either extension keeps a non-zero operand non-zero, so the widened copy suffices.
        a_nz    = |s1_a;
        b_nz    = |s1_b;
        flags_d = {eq, !eq, gt, !lt, lt, !gt, a_nz, b_nz};
    end

    always_comb begin
        s2_adv    = !s2_v || out_ready;
        s1_adv    = !s1_v || s2_adv;
        in_ready  = s1_adv;
        out_valid = s2_v;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v      <= 1'b0;
            s2_v      <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            flags     <= 8'h00;
            cmp_count <= '0;
        end else begin
            if (sclr) begin
                s1_v <= 1'b0;
                s2_v <= 1'b0;
            end else begin
                if (s1_adv) begin
                    s1_v <= in_valid;
                    if (in_valid) begin
                        s1_a <= a_w;
                        s1_b <= b_w;
                    end
                end
                if (s2_adv) begin
                    s2_v <= s1_v;
                    if (s1_v) begin
                        flags <= flags_d;
                    end
                end
            end
            // The word on the port this cycle is consumed even if sclr is also high.
            if (out_valid && out_ready) begin
                cmp_count <= cmp_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cmp_flags_stage.sv
// Bench for cmp_flags_stage: directed vectors plus randomized traffic with a queued scoreboard.
// A second instance with a 4-bit counter mirrors the main one to exercise counter wrap.
module tb_cmp_flags_stage;
  localparam int A_W = 6;
  localparam int B_W = 7;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic sclr;
  logic in_valid;
  logic in_ready;
  logic [A_W-1:0] a;
  logic [B_W-1:0] b;
  logic out_valid;
  logic out_ready;
  logic [7:0] flags;
  logic [CNT_W-1:0] cmp_count;
  logic in_ready4;
  logic out_valid4;
  logic [7:0] flags4;
  logic [3:0] cmp_count4;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [CNT_W-1:0] exp_count;
  logic prev_stall;
  logic prev_sclr;
  logic [7:0] prev_flags;

  cmp_flags_stage #(.A_W(A_W), .B_W(B_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .sclr(sclr), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .flags(flags),
    .cmp_count(cmp_count)
  );

  cmp_flags_stage #(.A_W(A_W), .B_W(B_W), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .sclr(sclr), .in_valid(in_valid), .in_ready(in_ready4),
    .a(a), .b(b), .out_valid(out_valid4), .out_ready(out_ready), .flags(flags4),
    .cmp_count(cmp_count4)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: plain integer arithmetic on the operand values
  function automatic logic [7:0] model(input int unsigned av, input int unsigned bv);
    int sa;
    int sb;
    sa = int'(av);
    sb = int'(bv);
`ifdef CMP_FLAGS_SIGNED_EN
    if (av >= (1 << (A_W - 1))) sa = int'(av) - (1 << A_W);
    if (bv >= (1 << (B_W - 1))) sb = int'(bv) - (1 << B_W);
`endif
    return {sa == sb, sa != sb, sa > sb, sa >= sb, sa < sb, sa <= sb, av != 0, bv != 0};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  // scoreboard input side: record the expected word for every accepted pair
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
    end else if (sclr) begin
      exp_q.delete();
    end else if (in_valid && in_ready) begin
      exp_q.push_back(model(32'(a), 32'(b)));
    end
  end

  // monitor: sample away from the active edge, pop on every output transfer
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst_n) begin
      exp_count = '0;
      prev_stall = 1'b0;
      prev_sclr = 1'b0;
      prev_flags = 8'h00;
    end else begin
      if (prev_stall && !prev_sclr) begin
        check("stall_valid_hold", 32'(out_valid), 32'd1);
        check("stall_flags_hold", 32'(flags), 32'(prev_flags));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("flags", 32'(flags), 32'(e));
        end
        check("cmp_count", 32'(cmp_count), 32'(exp_count));
        check("cmp_count_w4", 32'(cmp_count4), 32'(exp_count[3:0]));
        check("mirror", 32'({in_ready4, out_valid4, flags4}), 32'({in_ready, out_valid, flags}));
        exp_count = exp_count + CNT_W'(1);
      end
      prev_stall = out_valid && !out_ready;
      prev_sclr = sclr;
      prev_flags = flags;
    end
  end

  // driver tasks
  task automatic rand_pair();
    a = A_W'($urandom_range(0, (1 << A_W) - 1));
    case ($urandom_range(0, 7))
      0: b = B_W'(a);
      1: begin a = '0; b = '0; end
      default: b = B_W'($urandom_range(0, (1 << B_W) - 1));
    endcase
  endtask

  task automatic directed(input logic [A_W-1:0] av, input logic [B_W-1:0] bv,
                          input logic [7:0] expf, input string nm);
    @(posedge clk); #1;
    a = av; b = bv; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({nm, "_lat1"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check({nm, "_lat2"}, 32'(out_valid), 32'd1);
    check(nm, 32'(flags), 32'(expf));
  endtask

  task automatic drain();
    in_valid = 1'b0; sclr = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [CNT_W-1:0] c0;
    rst_n = 1'b0; sclr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_count", 32'(cmp_count), 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // directed vectors
`ifdef CMP_FLAGS_SIGNED_EN
    directed(6'h2A, 7'h2A, 8'b0100_1111, "equal_bits");
    directed(6'h3F, 7'h40, 8'b0111_0011, "width_ext");
`else
    directed(6'h2A, 7'h2A, 8'b1001_0111, "equal_vals");
    directed(6'h3F, 7'h40, 8'b0100_1111, "width_ext");
`endif
    directed(6'h00, 7'h00, 8'b1001_0100, "zero_ops");
    @(posedge clk); #1;
    check("count_after_directed", 32'(cmp_count), 32'd3);
    check("idle_after_directed", 32'(out_valid), 32'd0);

    // backpressure: two accepts fill the pipe, then ready drops
    c0 = cmp_count;
    out_ready = 1'b0; in_valid = 1'b1; rand_pair();
    @(negedge clk);
    check("bp_ready_first", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rand_pair();
    @(negedge clk);
    check("bp_ready_second", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rand_pair();
    repeat (5) begin
      @(negedge clk);
      check("bp_ready_drop", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    rand_pair();
    @(posedge clk); #1;
    drain();
    check("bp_count", 32'(cmp_count - c0), 32'd4);

    // asynchronous reset with both stages full
    out_ready = 1'b0; in_valid = 1'b1; rand_pair();
    @(posedge clk); #1;
    rand_pair();
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_flags", 32'(flags), 32'd0);
    check("async_rst_count", 32'(cmp_count), 32'd0);
    check("async_rst_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // synchronous clear with two entries in flight
    out_ready = 1'b0; in_valid = 1'b1; rand_pair();
    @(posedge clk); #1;
    out_ready = 1'b1; rand_pair();
    @(posedge clk); #1;
    out_ready = 1'b0;
    c0 = cmp_count;
    sclr = 1'b1; rand_pair();
    @(posedge clk); #1;
    sclr = 1'b0; in_valid = 1'b0;
    check("sclr_valid", 32'(out_valid), 32'd0);
    check("sclr_count", 32'(cmp_count), 32'(c0));
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("sclr_dropped", 32'(out_valid), 32'd0);

    // randomized traffic with random backpressure and rare clears
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      in_valid = ($urandom_range(0, 3) != 0);
      rand_pair();
      out_ready = ($urandom_range(0, 3) != 0);
      sclr = ($urandom_range(0, 99) == 0);
    end
    @(posedge clk); #1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
